// File: rtl/stopwatch_controller_if.sv
// Button, divider and display signals between the stopwatch controller and
// its surroundings. The master side drives button pulses and the divider tick.
interface stopwatch_controller_if;
    logic       StartStop;
    logic       Lap;
    logic       Clear;
    logic       Tick_100Hz;
    logic       DividerEnable;
    logic       DividerReset;
    logic [7:0] DisplayCS;
    logic [7:0] DisplaySec;
    logic [7:0] DisplayMin;
    logic       Running;
    logic       LapActive;
    logic       Overflow;

    modport master (
        output StartStop, Lap, Clear, Tick_100Hz,
        input  DividerEnable, DividerReset, DisplayCS, DisplaySec, DisplayMin,
               Running, LapActive, Overflow
    );

    modport slave (
        input  StartStop, Lap, Clear, Tick_100Hz,
        output DividerEnable, DividerReset, DisplayCS, DisplaySec, DisplayMin,
               Running, LapActive, Overflow
    );
endinterface

// File: rtl/stopwatch_controller.sv
// Stopwatch sequencing controller: run/pause/lap/clear FSM, divider control,
// and a saturating BCD mm:ss.cc counter fed by the divider's 100 Hz output.
module stopwatch_controller #(
    parameter logic [7:0] MAX_MINUTES = 8'h59,  // BCD, 01..99
    parameter int         CLEAR_HOLD  = 2       // 1..15 cycles
) (
    input  logic                   SysClock,
    input  logic                   Reset,
    stopwatch_controller_if.slave  sw
);
    typedef enum logic [2:0] {
        IDLE,
        RUNNING,
        PAUSED,
        LAP,
        CLEARING
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(CLEAR_HOLD - 1);

    state_t     state, state_nx;
    logic       clear_entry, lap_entry;
    logic [3:0] hold_cnt;
    logic       tick_hist, tick, enable;
    logic [7:0] cnt_cs, cnt_sec, cnt_min;
    logic [7:0] snap_cs, snap_sec, snap_min;
    logic [7:0] cs_nx, sec_nx, min_nx;
    logic       at_max, overflow;

    // State register
    always_ff @(posedge SysClock or posedge Reset) begin
        if (Reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Next-state decode; priority Clear > StartStop > Lap among legal inputs
    always_comb begin
        state_nx    = state;
        clear_entry = 1'b0;
        lap_entry   = 1'b0;
        case (state)
            IDLE: begin
                if (sw.Clear) begin
                    state_nx    = CLEARING;
                    clear_entry = 1'b1;
                end else if (sw.StartStop) begin
                    state_nx = RUNNING;
                end
            end
            RUNNING: begin
                if (sw.StartStop) begin
                    state_nx = PAUSED;
                end else if (sw.Lap) begin
                    state_nx  = LAP;
                    lap_entry = 1'b1;
                end
            end
            LAP: begin
                if (sw.StartStop)  state_nx = PAUSED;
                else if (sw.Lap)   state_nx = RUNNING;
            end
            PAUSED: begin
                if (sw.Clear) begin
                    state_nx    = CLEARING;
                    clear_entry = 1'b1;
                end else if (sw.StartStop) begin
                    state_nx = RUNNING;
                end
            end
            CLEARING: begin
                if (hold_cnt == HOLD_LAST) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Counts cycles spent in CLEARING so DividerReset lasts CLEAR_HOLD cycles
    always_ff @(posedge SysClock or posedge Reset) begin
        if (Reset)                  hold_cnt <= 4'd0;
        else if (clear_entry)       hold_cnt <= 4'd0;
        else if (state == CLEARING) hold_cnt <= hold_cnt + 4'd1;
    end

    assign enable = (state == RUNNING) || (state == LAP);

    // Tick history tracks the input in every state, so re-enabling while the
    // tick is already high cannot fake a rising edge
    always_ff @(posedge SysClock or posedge Reset) begin
        if (Reset) tick_hist <= 1'b0;
        else       tick_hist <= sw.Tick_100Hz;
    end

    assign tick = enable && !tick_hist && sw.Tick_100Hz;

    // BCD increment of mm:ss.cc with carries; at_max marks the saturation point
    always_comb begin
        cs_nx  = cnt_cs;
        sec_nx = cnt_sec;
        min_nx = cnt_min;
        at_max = (cnt_min == MAX_MINUTES) && (cnt_sec == 8'h59) && (cnt_cs == 8'h99);
        if (cnt_cs[3:0] != 4'd9) begin
            cs_nx[3:0] = cnt_cs[3:0] + 4'd1;
        end else if (cnt_cs[7:4] != 4'd9) begin
            cs_nx = {cnt_cs[7:4] + 4'd1, 4'd0};
        end else begin
            cs_nx = 8'h00;
            if (cnt_sec[3:0] != 4'd9) begin
                sec_nx[3:0] = cnt_sec[3:0] + 4'd1;
            end else if (cnt_sec[7:4] != 4'd5) begin
                sec_nx = {cnt_sec[7:4] + 4'd1, 4'd0};
            end else begin
                sec_nx = 8'h00;
                if (cnt_min[3:0] != 4'd9) min_nx[3:0] = cnt_min[3:0] + 4'd1;
                else                      min_nx = {cnt_min[7:4] + 4'd1, 4'd0};
            end
        end
    end

    // Live count, lap snapshot and sticky overflow; all zeroed on entering CLEARING
    always_ff @(posedge SysClock or posedge Reset) begin
        if (Reset) begin
            cnt_cs   <= 8'h00;
            cnt_sec  <= 8'h00;
            cnt_min  <= 8'h00;
            snap_cs  <= 8'h00;
            snap_sec <= 8'h00;
            snap_min <= 8'h00;
            overflow <= 1'b0;
        end else if (clear_entry) begin
            cnt_cs   <= 8'h00;
            cnt_sec  <= 8'h00;
            cnt_min  <= 8'h00;
            snap_cs  <= 8'h00;
            snap_sec <= 8'h00;
            snap_min <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (tick) begin
                if (at_max) begin
                    overflow <= 1'b1;
                end else begin
                    cnt_cs  <= cs_nx;
                    cnt_sec <= sec_nx;
                    cnt_min <= min_nx;
                end
            end
            // Snapshot takes the pre-tick value if a tick lands on the same edge
            if (lap_entry) begin
                snap_cs  <= cnt_cs;
                snap_sec <= cnt_sec;
                snap_min <= cnt_min;
            end
        end
    end

    assign sw.DividerEnable = enable;
    assign sw.DividerReset  = (state == CLEARING);
    assign sw.Running       = enable;
    assign sw.LapActive     = (state == LAP);
    assign sw.Overflow      = overflow;
    assign sw.DisplayCS     = (state == LAP) ? snap_cs  : cnt_cs;
    assign sw.DisplaySec    = (state == LAP) ? snap_sec : cnt_sec;
    assign sw.DisplayMin    = (state == LAP) ? snap_min : cnt_min;
endmodule

// File: tb/tb_stopwatch_controller.sv
// Bench for stopwatch_controller: two instances (default and MAX_MINUTES=1)
// share one stimulus stream; a centisecond-based model feeds a scoreboard.
module tb_stopwatch_controller;
    localparam int M_IDLE = 0, M_RUN = 1, M_PAU = 2, M_LAP = 3, M_CLR = 4;
    localparam int MAX_A = 59 * 6000 + 5999;
    localparam int MAX_B = 1 * 6000 + 5999;

    typedef struct {
        string       tag;
        logic [28:0] a;
        logic [28:0] b;
    } exp_t;

    logic SysClock = 1'b0;
    logic Reset;
    int   checks = 0;
    int   failures = 0;
    int   mst, cnt, snap;
    exp_t exp_q[$];

    stopwatch_controller_if ifa();
    stopwatch_controller_if ifb();

    assign ifb.StartStop  = ifa.StartStop;
    assign ifb.Lap        = ifa.Lap;
    assign ifb.Clear      = ifa.Clear;
    assign ifb.Tick_100Hz = ifa.Tick_100Hz;

    stopwatch_controller dut_a (.SysClock(SysClock), .Reset(Reset), .sw(ifa));
    stopwatch_controller #(.MAX_MINUTES(8'h01)) dut_b (.SysClock(SysClock), .Reset(Reset), .sw(ifb));

    always #5 SysClock = ~SysClock;

    logic [28:0] obs_a, obs_b;
    assign obs_a = {ifa.DividerEnable, ifa.DividerReset, ifa.DisplayMin, ifa.DisplaySec,
                    ifa.DisplayCS, ifa.Running, ifa.LapActive, ifa.Overflow};
    assign obs_b = {ifb.DividerEnable, ifb.DividerReset, ifb.DisplayMin, ifb.DisplaySec,
                    ifb.DisplayCS, ifb.Running, ifb.LapActive, ifb.Overflow};

    function automatic logic [7:0] bcd(int v);
        logic [3:0] h, l;
        h = 4'(v / 10);
        l = 4'(v % 10);
        return {h, l};
    endfunction

    function automatic logic [28:0] exp_word(int mx);
        int   d;
        logic act;
        d = (mst == M_LAP) ? snap : cnt;
        if (d > mx) d = mx;
        act = (mst == M_RUN) || (mst == M_LAP);
        return {act, (mst == M_CLR), bcd(d / 6000), bcd((d / 100) % 60), bcd(d % 100),
                act, (mst == M_LAP), (cnt > mx)};
    endfunction

    task automatic push_exp(input string tag);
        exp_t e;
        e.tag = tag;
        e.a   = exp_word(MAX_A);
        e.b   = exp_word(MAX_B);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        ifa.StartStop = 1'b0; ifa.Lap = 1'b0; ifa.Clear = 1'b0; ifa.Tick_100Hz = 1'b0;
        mst = M_IDLE; cnt = 0; snap = 0;
        @(posedge SysClock); #1;
        @(posedge SysClock); #1;
        Reset = 1'b0;
    endtask

    // One-cycle button pulse; the model applies the same priority rules
    task automatic pulse(input logic c, input logic s, input logic l);
        @(posedge SysClock); #1;
        ifa.Clear = c; ifa.StartStop = s; ifa.Lap = l;
        case (mst)
            M_IDLE: if (c) begin mst = M_CLR; cnt = 0; snap = 0; end
                    else if (s) mst = M_RUN;
            M_RUN:  if (s) mst = M_PAU;
                    else if (l) begin mst = M_LAP; snap = cnt; end
            M_LAP:  if (s) mst = M_PAU;
                    else if (l) mst = M_RUN;
            M_PAU:  if (c) begin mst = M_CLR; cnt = 0; snap = 0; end
                    else if (s) mst = M_RUN;
            default: ;
        endcase
        @(posedge SysClock); #1;
        ifa.Clear = 1'b0; ifa.StartStop = 1'b0; ifa.Lap = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge SysClock); #1;
            ifa.Tick_100Hz = 1'b1;
            if (mst == M_RUN || mst == M_LAP) cnt++;
            @(posedge SysClock); #1;
            ifa.Tick_100Hz = 1'b0;
        end
    endtask

    task automatic finish_clear();
        @(posedge SysClock); #1;
        @(posedge SysClock); #1;
        mst = M_IDLE;
    endtask

    task automatic test_reset();
        exp_t e;
        Reset = 1'b1;
        ifa.StartStop = 1'b0; ifa.Lap = 1'b0; ifa.Clear = 1'b0; ifa.Tick_100Hz = 1'b0;
        mst = M_IDLE; cnt = 0; snap = 0;
        push_exp("reset_held");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        @(posedge SysClock); #1;
        Reset = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        push_exp("idle_lap_ignored");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
    endtask

    task automatic test_run();
        exp_t e;
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        push_exp("run_enable");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        ticks(150);
        push_exp("run_150_ticks");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
    endtask

    task automatic test_lap();
        exp_t e;
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        ticks(20);
        pulse(1'b0, 1'b0, 1'b1);
        push_exp("lap_enter");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        ticks(30);
        push_exp("lap_frozen");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        pulse(1'b0, 1'b0, 1'b1);
        push_exp("lap_release");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        pulse(1'b0, 1'b0, 1'b1);
        ticks(10);
        pulse(1'b0, 1'b1, 1'b0);
        push_exp("lap_to_pause_live");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
    endtask

    task automatic test_pause();
        exp_t e;
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        ticks(10);
        pulse(1'b0, 1'b1, 1'b0);
        ticks(20);
        push_exp("pause_hold");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        // Tick already high across resume: no rising edge, so no count
        @(posedge SysClock); #1;
        ifa.Tick_100Hz = 1'b1;
        pulse(1'b0, 1'b1, 1'b0);
        @(posedge SysClock); #1;
        @(posedge SysClock); #1;
        push_exp("resume_no_spurious");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        @(posedge SysClock); #1;
        ifa.Tick_100Hz = 1'b0;
        ticks(5);
        push_exp("resume_count");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
    endtask

    task automatic test_clear();
        exp_t e;
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        ticks(5);
        pulse(1'b1, 1'b0, 1'b0);
        ticks(5);
        push_exp("clear_ignored_run");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        push_exp("clear_hold_1");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        push_exp("clear_hold_2");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        mst = M_IDLE;
        push_exp("clear_done_idle");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
    endtask

    task automatic test_overflow();
        exp_t e;
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        ticks(MAX_B);
        push_exp("at_max_b");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        ticks(3);
        push_exp("saturated_b");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);
        push_exp("overflow_cleared");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        finish_clear();
    endtask

    task automatic test_priority();
        exp_t e;
        do_reset();
        pulse(1'b0, 1'b1, 1'b0);
        ticks(3);
        pulse(1'b0, 1'b1, 1'b1);
        push_exp("run_start_beats_lap");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        pulse(1'b1, 1'b1, 1'b0);
        push_exp("paused_clear_wins");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        finish_clear();
        pulse(1'b1, 1'b1, 1'b0);
        push_exp("idle_clear_wins");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        finish_clear();
        pulse(1'b0, 1'b1, 1'b0);
        ticks(4);
        pulse(1'b1, 1'b0, 1'b1);
        ticks(2);
        push_exp("run_clear_lap_is_lap");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        // Asynchronous reset between edges while in LAP
        #2;
        Reset = 1'b1;
        mst = M_IDLE; cnt = 0; snap = 0;
        push_exp("async_reset_lap");
        #1; e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
        @(posedge SysClock); #1;
        Reset = 1'b0;
        push_exp("after_reset_idle");
        @(negedge SysClock); e = exp_q.pop_front(); checks++;
        if ({obs_a, obs_b} !== {e.a, e.b}) begin failures++;
            $display("FAIL %s a=%h want %h b=%h want %h", e.tag, obs_a, e.a, obs_b, e.b); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_lap();
        test_pause();
        test_clear();
        test_priority();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stopwatch_controller.md
Name: stopwatch_controller

Overview:
- Sequencing controller for the stopwatch clock-divider datapath.
- Decodes single-cycle StartStop/Lap/Clear button pulses into a run/pause/lap/clear state machine.
- Drives the divider's Enable and Reset inputs.
- Counts rising edges of the divider's 100 Hz output into a BCD mm:ss.cc time value, with lap-freeze of the displayed value.

Parameters:
- MAX_MINUTES, 59: highest minute value before saturation; BCD, legal range 1..99.
- CLEAR_HOLD, 2: number of SysClock cycles DividerReset is held high when clearing; legal range 1..15.

Ports:
- SysClock  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- StartStop  input  1  single-cycle pulse, synchronous to SysClock.
- Lap  input  1  single-cycle pulse, synchronous.
- Clear  input  1  single-cycle pulse, synchronous.
- Tick_100Hz  input  1  100 Hz square wave from the divider, generated in the SysClock domain.
- DividerEnable  output  1  enable to the clock divider.
- DividerReset  output  1  synchronous clear to the clock divider.
- DisplayCS  output  8  centiseconds, two BCD digits (00-99).
- DisplaySec  output  8  seconds, two BCD digits (00-59).
- DisplayMin  output  8  minutes, two BCD digits (00-MAX_MINUTES).
- Running  output  1  high in RUNNING and LAP.
- LapActive  output  1  high in LAP.
- Overflow  output  1  sticky saturation flag.

Behaviour:
- Reset (async, immediate, no clock needed):
  - State goes to IDLE.
  - Count, snapshot, tick-history register and CLEAR_HOLD counter all go to 0.
  - Every output is 0.
- States: IDLE, RUNNING, PAUSED, LAP, CLEARING. Moore outputs are decoded from the registered state, so an output changes on the cycle after the input pulse.
- Input priority within a single cycle: Clear > StartStop > Lap. Only the highest-priority input that is legal in the current state acts; the others are dropped.
- IDLE:
  - StartStop -> RUNNING.
  - Clear -> CLEARING.
  - Lap ignored.
- RUNNING:
  - StartStop -> PAUSED.
  - Lap -> LAP, snapshotting the current count into the snapshot registers on the same edge.
  - Clear ignored.
- LAP:
  - Internal count keeps advancing; Display* show the snapshot.
  - Lap -> RUNNING; Display* follow the live count again.
  - StartStop -> PAUSED; Display* show the live count.
  - Clear ignored.
- PAUSED:
  - StartStop -> RUNNING.
  - Clear -> CLEARING.
  - Lap ignored.
- CLEARING:
  - DividerReset = 1 for exactly CLEAR_HOLD cycles.
  - Count, snapshot and Overflow are zeroed on entry.
  - Then -> IDLE.
  - All inputs are ignored while in CLEARING.
- DividerEnable = 1 only in RUNNING and LAP. DividerReset = 1 only in CLEARING.
- Tick detection:
  - A one-bit history register samples Tick_100Hz every cycle, in every state.
  - A tick is history=0 and Tick_100Hz=1, qualified by DividerEnable.
  - Ticks while disabled are discarded and are never queued.
  - Re-enabling never produces a spurious tick, because the history register is always up to date.
- Count, one BCD increment per tick:
  - CS rolls 99 -> 00 with a carry into Sec.
  - Sec rolls 59 -> 00 with a carry into Min.
  - Min increments normally.
  - At MAX_MINUTES:59.99 a further tick leaves the count unchanged and sets Overflow = 1.
  - Overflow is sticky until CLEARING or Reset. The state machine is unaffected by saturation.
- Display* is a mux of the count and snapshot registers with no added latency: it reflects a tick on the cycle after the tick edge.
- Reset asserted mid-operation, in any state, aborts immediately to IDLE with zero count.

Test Plan:
1. Reset, then StartStop pulse, then 150 Tick_100Hz rising edges -> DividerEnable = 1 from the cycle after the pulse; Display reads 00:01.50; Running = 1.
2. In RUNNING at 00:00.20, Lap pulse, then 30 ticks -> Display holds 00:00.20 with LapActive = 1. Second Lap pulse -> Display shows 00:00.50, LapActive = 0.
3. RUNNING at 00:00.10, StartStop pulse, then 20 ticks -> Display stays 00:00.10 and DividerEnable = 0. StartStop again, then 5 ticks -> Display 00:00.15.
4. Clear pulse in RUNNING -> ignored, count keeps advancing. Clear pulse in PAUSED -> DividerReset high for exactly 2 cycles, Display 00:00.00, then IDLE with all outputs 0.
5. With MAX_MINUTES = 1: run to 01:59.99, then 3 more ticks -> Display stays 01:59.99 and Overflow = 1. Clear from PAUSED -> Overflow = 0.
6. Clear and StartStop in the same cycle in PAUSED -> CLEARING (Clear wins). Async Reset asserted mid-LAP between clock edges -> all outputs 0 immediately, state IDLE.
